// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings, bubble constants and postif_id FSM states
package cpu_defs;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] BUBBLE_PC = 32'h0;
  localparam logic [31:0] BUBBLE_EXC = 32'h0;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_DISCARD} postif_id_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
    logic        valid;
  } fetch_t;
  localparam fetch_t BUBBLE = '{pc: BUBBLE_PC, inst: NOP_INST, exc: BUBBLE_EXC, valid: 1'b0};
endpackage

// File: rtl/postif_id_buf.sv
// postif_id_buf: single-entry capture register for a response that arrives while decode is stalled
module postif_id_buf
  import cpu_defs::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   load_i,
  input  logic   clear_i,
  input  fetch_t d_i,
  output fetch_t q_o
);
  fetch_t buf_q, buf_d;
  // load wins over clear; otherwise hold
  always_comb buf_d = load_i ? d_i : (clear_i ? BUBBLE : buf_q);
  // capture register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) buf_q <= BUBBLE;
    else buf_q <= buf_d;
  end
  assign q_o = buf_q;
endmodule

// File: rtl/postif_id.sv
// postif_id: postif->id pipeline register completing the icache handshake; `POSTIF_ID_PERF_EN adds wait_cycles_o
module postif_id
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] exception_type_i,
  input  logic        inst_ren_i,
  input  logic        inst_ok_i,
  input  logic        inst_valid_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_exception_type_o,
  output logic        id_valid_o,
`ifdef POSTIF_ID_PERF_EN
  output logic [31:0] wait_cycles_o,
`endif
  output logic        postif_id_stall_o
);
  postif_id_state_t state_q, state_d;
  fetch_t out_q, out_d, buf_q, in_word;
  logic buf_load, buf_clear, pending, wait_stall;
  assign in_word = {pc_i, inst_i, exception_type_i, inst_valid_i};
  assign pending = (state_q == ST_WAIT) || (state_q == ST_IDLE && inst_ren_i);
  assign wait_stall = inst_ren_i & ~inst_ok_i & (state_q == ST_IDLE || state_q == ST_WAIT);
  assign postif_id_stall_o = wait_stall | (state_q == ST_HOLD) | (state_q == ST_DISCARD);
  postif_id_buf u_buf (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .d_i     (in_word),
    .q_o     (buf_q)
  );
  // next state and next id outputs: flush > stall > advance
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    buf_load = 1'b0;
    buf_clear = 1'b0;
    if (flush_i) begin
      out_d = BUBBLE;
      buf_clear = 1'b1;
      state_d = (pending && !inst_ok_i) ? ST_DISCARD : ST_IDLE;
    end else if (state_q == ST_DISCARD) begin
      if (inst_ok_i) state_d = ST_IDLE;
    end else if (state_q == ST_HOLD) begin
      if (!stall_i) begin
        out_d = buf_q;
        buf_clear = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (inst_ren_i) begin
      if (!inst_ok_i) begin
        state_d = ST_WAIT;
        if (!stall_i) out_d = BUBBLE;
      end else if (stall_i) begin
        buf_load = 1'b1;
        state_d = ST_HOLD;
      end else begin
        out_d = in_word;
        state_d = ST_IDLE;
      end
    end else begin
      state_d = ST_IDLE;
      if (!stall_i) out_d = (|exception_type_i) ? {pc_i, NOP_INST, exception_type_i, 1'b1} : BUBBLE;
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      out_q <= BUBBLE;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
    end
  end
  assign id_pc_o = out_q.pc;
  assign id_inst_o = out_q.inst;
  assign id_exception_type_o = out_q.exc;
  assign id_valid_o = out_q.valid;
`ifdef POSTIF_ID_PERF_EN
  logic [31:0] wait_q, wait_d;
  // saturating count of cycles stalled waiting on or discarding a response
  always_comb wait_d = ((wait_stall || state_q == ST_DISCARD) && !(&wait_q)) ? wait_q + 32'd1 : wait_q;
  // counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!resetn) wait_q <= 32'd0;
    else wait_q <= wait_d;
  end
  assign wait_cycles_o = wait_q;
`endif
endmodule

// File: tb/tb_postif_id.sv
// tb_postif_id: directed scenarios plus randomized run against a behavioural model of postif_id
module tb_postif_id;
  logic clk = 1'b0, resetn = 1'b0, flush_i = 1'b0, stall_i = 1'b0;
  logic [31:0] pc_i = '0, inst_i = '0, exception_type_i = '0;
  logic inst_ren_i = 1'b0, inst_ok_i = 1'b0, inst_valid_i = 1'b0;
  logic [31:0] id_pc_o, id_inst_o, id_exception_type_o;
  logic id_valid_o, postif_id_stall_o;
  int checks = 0, failures = 0;
`ifdef POSTIF_ID_PERF_EN
  logic [31:0] wait_cycles_o;
`endif

  typedef struct {logic [31:0] pc, inst, exc; logic v;} tup_t;

  postif_id dut (
    .clk                 (clk),
    .resetn              (resetn),
    .flush_i             (flush_i),
    .stall_i             (stall_i),
    .pc_i                (pc_i),
    .inst_i              (inst_i),
    .exception_type_i    (exception_type_i),
    .inst_ren_i          (inst_ren_i),
    .inst_ok_i           (inst_ok_i),
    .inst_valid_i        (inst_valid_i),
    .id_pc_o             (id_pc_o),
    .id_inst_o           (id_inst_o),
    .id_exception_type_o (id_exception_type_o),
    .id_valid_o          (id_valid_o),
`ifdef POSTIF_ID_PERF_EN
    .wait_cycles_o       (wait_cycles_o),
`endif
    .postif_id_stall_o   (postif_id_stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i = 0; stall_i = 0; inst_ren_i = 0; inst_ok_i = 0; inst_valid_i = 0;
    pc_i = 0; inst_i = 0; exception_type_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    tick(); tick();
    checks++;
    if ({id_pc_o, id_inst_o, id_exception_type_o, id_valid_o, postif_id_stall_o} !== 98'd0) begin
      failures++;
      $display("FAIL reset: pc=%h inst=%h exc=%h v=%b stall=%b expected all 0", id_pc_o, id_inst_o, id_exception_type_o, id_valid_o, postif_id_stall_o);
    end
`ifdef POSTIF_ID_PERF_EN
    checks++;
    if (wait_cycles_o !== 32'd0) begin failures++; $display("FAIL reset_wait: got %0d expected 0", wait_cycles_o); end
`endif
    resetn = 1;
  endtask

  task automatic test_hit();
    pc_i = 32'hBFC00000; inst_i = 32'h24080001; inst_ren_i = 1; inst_ok_i = 1; inst_valid_i = 1;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b0) begin failures++; $display("FAIL hit_stall: got %b expected 0", postif_id_stall_o); end
    tick();
    checks++;
    if (id_pc_o !== 32'hBFC00000 || id_inst_o !== 32'h24080001 || id_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL hit: pc=%h inst=%h v=%b expected bfc00000 24080001 1", id_pc_o, id_inst_o, id_valid_o);
    end
    inst_ren_i = 0; inst_ok_i = 0;
  endtask

  task automatic test_miss();
    pc_i = 32'hBFC00004; inst_ren_i = 1; inst_ok_i = 0; inst_valid_i = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++;
      if (postif_id_stall_o !== 1'b1) begin failures++; $display("FAIL miss_stall c%0d: got %b expected 1", c, postif_id_stall_o); end
      tick();
      checks++;
      if (id_valid_o !== 1'b0 || id_inst_o !== 32'd0 || id_pc_o !== 32'd0) begin
        failures++;
        $display("FAIL miss_bubble c%0d: pc=%h inst=%h v=%b expected bubble", c, id_pc_o, id_inst_o, id_valid_o);
      end
    end
    inst_ok_i = 1; inst_i = 32'h3C1D8000;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b0) begin failures++; $display("FAIL miss_ok_stall: got %b expected 0", postif_id_stall_o); end
    tick();
    checks++;
    if (id_pc_o !== 32'hBFC00004 || id_inst_o !== 32'h3C1D8000 || id_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL miss_data: pc=%h inst=%h v=%b expected bfc00004 3c1d8000 1", id_pc_o, id_inst_o, id_valid_o);
    end
`ifdef POSTIF_ID_PERF_EN
    checks++;
    if (wait_cycles_o !== 32'd3) begin failures++; $display("FAIL miss_wait_cycles: got %0d expected 3", wait_cycles_o); end
`endif
  endtask

  task automatic test_stall_response();
    pc_i = 32'hBFC00008; inst_i = 32'h8C090004; inst_ren_i = 1; inst_ok_i = 1; inst_valid_i = 1; stall_i = 1;
    tick();
    inst_ok_i = 0; inst_i = 32'hFFFFFFFF;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (id_pc_o !== 32'hBFC00004 || id_inst_o !== 32'h3C1D8000 || id_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL stall_frozen c%0d: pc=%h inst=%h v=%b expected bfc00004 3c1d8000 1", c, id_pc_o, id_inst_o, id_valid_o);
      end
      checks++;
      if (postif_id_stall_o !== 1'b1) begin failures++; $display("FAIL stall_hold_req c%0d: got %b expected 1", c, postif_id_stall_o); end
      if (c == 0) tick();
    end
    stall_i = 0;
    tick();
    checks++;
    if (id_pc_o !== 32'hBFC00008 || id_inst_o !== 32'h8C090004 || id_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: pc=%h inst=%h v=%b expected bfc00008 8c090004 1", id_pc_o, id_inst_o, id_valid_o);
    end
    inst_ren_i = 0;
  endtask

  task automatic test_flush();
    pc_i = 32'hBFC0000C; inst_ren_i = 1; inst_ok_i = 0;
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    checks++;
    if (id_valid_o !== 1'b0 || id_inst_o !== 32'd0 || id_pc_o !== 32'd0 || id_exception_type_o !== 32'd0) begin
      failures++;
      $display("FAIL flush_bubble: pc=%h inst=%h v=%b expected bubble", id_pc_o, id_inst_o, id_valid_o);
    end
    inst_ren_i = 0;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b1) begin failures++; $display("FAIL flush_discard_stall: got %b expected 1", postif_id_stall_o); end
    tick();
    inst_ok_i = 1; inst_i = 32'hDEADBEEF; inst_valid_i = 1;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b1) begin failures++; $display("FAIL flush_ok_stall: got %b expected 1", postif_id_stall_o); end
    tick();
    inst_ok_i = 0;
    checks++;
    if (id_inst_o !== 32'd0 || id_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_dropped: inst=%h v=%b expected 0 0", id_inst_o, id_valid_o);
    end
    inst_ren_i = 1; pc_i = 32'hBFC00010;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b1) begin failures++; $display("FAIL flush_idle_after: stall=%b expected 1 (new request in IDLE)", postif_id_stall_o); end
    inst_ren_i = 0;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b0) begin failures++; $display("FAIL flush_idle_quiet: stall=%b expected 0", postif_id_stall_o); end
  endtask

  task automatic test_exception();
    idle_inputs();
    pc_i = 32'hBFC00001; exception_type_i = 32'h10;
    tick();
    checks++;
    if (id_pc_o !== 32'hBFC00001 || id_inst_o !== 32'd0 || id_exception_type_o !== 32'h10 || id_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL exception: pc=%h inst=%h exc=%h v=%b expected bfc00001 0 10 1", id_pc_o, id_inst_o, id_exception_type_o, id_valid_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_hold();
    pc_i = 32'hBFC00020; inst_i = 32'h11112222; inst_ren_i = 1; inst_ok_i = 1; inst_valid_i = 1; stall_i = 1;
    tick();
    idle_inputs(); stall_i = 1; resetn = 0;
    tick();
    resetn = 1;
    checks++;
    if ({id_pc_o, id_inst_o, id_exception_type_o, id_valid_o} !== 97'd0) begin
      failures++;
      $display("FAIL hold_reset: pc=%h inst=%h v=%b expected all 0", id_pc_o, id_inst_o, id_valid_o);
    end
    stall_i = 0;
    tick();
    checks++;
    if (id_inst_o !== 32'd0 || id_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL hold_stale: inst=%h v=%b expected 0 0", id_inst_o, id_valid_o);
    end
    inst_ren_i = 1; pc_i = 32'hBFC00030;
    tick();
    inst_ren_i = 0; resetn = 0;
    tick();
    resetn = 1; inst_ok_i = 1; inst_i = 32'hCAFEF00D; inst_valid_i = 1;
    #1;
    checks++;
    if (postif_id_stall_o !== 1'b0) begin failures++; $display("FAIL stray_stall: got %b expected 0", postif_id_stall_o); end
    tick();
    checks++;
    if (id_inst_o !== 32'd0 || id_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stray_ok: inst=%h v=%b expected 0 0", id_inst_o, id_valid_o);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    tup_t held[$];
    tup_t outs;
    bit disc, req_out, exp_stall;
    int m_wait;
    idle_inputs();
    resetn = 0;
    tick();
    resetn = 1;
    outs = '{0, 0, 0, 1'b0};
    disc = 0; req_out = 0; m_wait = 0;
    for (int i = 0; i < 400; i++) begin
      flush_i = ($urandom % 10) == 0;
      stall_i = ($urandom % 3) == 0;
      if (!req_out) pc_i = $urandom;
      inst_ren_i = req_out ? 1'b1 : 1'($urandom % 2);
      inst_ok_i = ($urandom % 3) == 0;
      inst_i = $urandom;
      inst_valid_i = ($urandom % 4) != 0;
      exception_type_i = ($urandom % 4) == 0 ? $urandom : 32'd0;
      @(negedge clk);
      exp_stall = disc || held.size() != 0 || (inst_ren_i && !inst_ok_i);
      checks++;
      if (postif_id_stall_o !== exp_stall) begin
        failures++;
        $display("FAIL rand_stall #%0d: got %b expected %b", i, postif_id_stall_o, exp_stall);
      end
      if (disc || (held.size() == 0 && inst_ren_i && !inst_ok_i)) m_wait++;
      if (flush_i) begin
        disc = !disc && held.size() == 0 && inst_ren_i && !inst_ok_i;
        req_out = 0;
        held.delete();
        outs = '{0, 0, 0, 1'b0};
      end else if (disc) begin
        if (inst_ok_i) disc = 0;
      end else if (held.size() != 0) begin
        if (!stall_i) outs = held.pop_front();
      end else if (inst_ren_i && inst_ok_i) begin
        req_out = 0;
        if (stall_i) held.push_back('{pc_i, inst_i, exception_type_i, inst_valid_i});
        else outs = '{pc_i, inst_i, exception_type_i, inst_valid_i};
      end else if (inst_ren_i) begin
        req_out = 1;
        if (!stall_i) outs = '{0, 0, 0, 1'b0};
      end else if (!stall_i) begin
        outs = exception_type_i != 0 ? '{pc_i, 32'd0, exception_type_i, 1'b1} : '{0, 0, 0, 1'b0};
      end
      tick();
      checks++;
      if (id_pc_o !== outs.pc || id_inst_o !== outs.inst || id_exception_type_o !== outs.exc || id_valid_o !== outs.v) begin
        failures++;
        $display("FAIL rand_out #%0d: got pc=%h inst=%h exc=%h v=%b expected pc=%h inst=%h exc=%h v=%b", i,
                 id_pc_o, id_inst_o, id_exception_type_o, id_valid_o, outs.pc, outs.inst, outs.exc, outs.v);
      end
    end
`ifdef POSTIF_ID_PERF_EN
    checks++;
    if (wait_cycles_o !== 32'(m_wait)) begin failures++; $display("FAIL rand_wait_cycles: got %0d expected %0d", wait_cycles_o, m_wait); end
`endif
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_stall_response();
    test_flush();
    test_exception();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/postif_id.md
# postif_id

Pipeline register between the post-fetch stage (`postif`) and instruction decode (`id`). Completes the instruction-cache handshake for the request issued by `pc`: waits for `inst_ok_i`, holds the returned word while decode is stalled, and discards a response still in flight when a flush arrives. Presents one registered {pc, inst, exception_type, valid} tuple to `id` per advance.

## Interface
- No parameters. Widths are fixed at 32 bits.
- `clk`  in  1  core clock.
- `resetn`  in  1  synchronous, active-low reset.
- `flush_i`  in  1  pipeline flush (exception/eret) from ctrl.
- `stall_i`  in  1  decode-side stall from ctrl. When high, the `id` outputs must not change.
- `pc_i`  in  32  fetch PC from `postif`. Held stable by upstream while `postif_id_stall_o` is high.
- `inst_i`  in  32  cache read data. Valid only in the cycle `inst_ok_i`=1.
- `exception_type_i`  in  32  fetch exception vector from `postif`.
- `inst_ren_i`  in  1  a fetch request is outstanding for `pc_i`.
- `inst_ok_i`  in  1  one-cycle cache response pulse.
- `inst_valid_i`  in  1  qualifies `inst_i`. Low with `inst_ok_i` means the cache cancelled the response.
- `id_pc_o`  out  32  registered PC to decode.
- `id_inst_o`  out  32  registered instruction. Bubble value is 0 (sll nop).
- `id_exception_type_o`  out  32  registered exception vector.
- `id_valid_o`  out  1  the `id` outputs carry a real instruction.
- `postif_id_stall_o`  out  1  stall request to ctrl, combinational.
- `wait_cycles_o`  out  32  present only under `POSTIF_ID_PERF_EN`.

## Operation
- FSM states:
  - IDLE: no pending response.
  - WAIT: request issued, no response yet.
  - HOLD: response captured into the buffer while `stall_i` is high.
  - DISCARD: a flushed request whose response is still in flight.
- Priority on each edge: reset > flush > stall > advance.
- IDLE/WAIT with `inst_ren_i`=1:
  - `inst_ok_i`=1 and `stall_i`=0: load outputs, `id_valid_o`=`inst_valid_i`, go to IDLE.
  - `inst_ok_i`=1 and `stall_i`=1: capture {pc, inst, exc, inst_valid} into the buffer, go to HOLD.
  - `inst_ok_i`=0: go to WAIT. If `stall_i`=0, outputs become a bubble.
- IDLE with `inst_ren_i`=0:
  - `exception_type_i`≠0 and `stall_i`=0: load pc/exc, inst=0, valid=1 (the faulting fetch reaches decode without a cache access).
  - Otherwise, if `stall_i`=0: bubble.
- HOLD: when `stall_i` falls, load outputs from the buffer and go to IDLE. No new request is accepted in the same cycle.
- Flush:
  - Outputs become a bubble on the next edge. The buffer is dropped.
  - State WAIT (or a request pending in IDLE) with `inst_ok_i`=0: go to DISCARD.
  - `inst_ok_i`=1 in the flush cycle: the response is dropped and the state goes to IDLE.
  - Any other state goes to IDLE.
- DISCARD: drop the next `inst_ok_i` pulse, then go to IDLE. Other inputs are ignored.
- `postif_id_stall_o` = (`inst_ren_i` & ~`inst_ok_i` & state∈{IDLE,WAIT}) | (state==DISCARD) | (state==HOLD).

## Timing
- Reset (`resetn`=0 at an edge): all outputs 0, state IDLE, buffer 0, counter 0.
- Latency: `inst_ok_i` in cycle n → `id_*` valid after edge n+1, when not stalled. A hit in the request cycle gives zero wait cycles.
- A bubble is pc=0, inst=0, exc=0, valid=0.
- `stall_i`=1 freezes the `id` outputs; only the buffer and the FSM update.
- `flush_i` and `inst_ok_i` in the same cycle: flush wins and the word is lost.
- `flush_i` and `stall_i` in the same cycle: flush wins.
- Reset during WAIT/DISCARD: state goes to IDLE. Any later stray `inst_ok_i` with `inst_ren_i`=0 is ignored.

## Configuration
- `POSTIF_ID_PERF_EN`:
  - Defined: `wait_cycles_o` is a 32-bit saturating counter of cycles with `postif_id_stall_o`=1 due to WAIT or DISCARD, cleared by reset only.
  - Undefined: the port and the counter are absent, with no other behavioural change.

## Structure
- Shared package `cpu_defs`:
  - NOP encoding (32'h0).
  - Bubble constants.
  - FSM state enum `postif_id_state_t`, 2 bits.
- Sub-module: `postif_id_buf` holds the single-entry capture register: load, clear, {pc, inst, exc, valid}.
- Everything else lives in `postif_id`.

## Test plan
- **Hit, no stall:** pc=0xBFC00000, `inst_ren_i`=1, `inst_ok_i`=1, `inst_i`=0x24080001 → next cycle `id_inst_o`=0x24080001, `id_valid_o`=1, stall_o never high.
- **Miss, 3 wait cycles:** ok arrives on cycle 4 → stall_o=1 on cycles 1–3, outputs a bubble, instruction valid after cycle 4. Under `POSTIF_ID_PERF_EN`, `wait_cycles_o`=3.
- **Response under stall:** ok with `stall_i`=1 for 2 cycles, `inst_i`=0x8C090004 → `id_*` frozen. One cycle after `stall_i` drops, `id_inst_o`=0x8C090004.
- **Flush mid-miss:** flush in WAIT, ok 2 cycles later with 0xDEADBEEF → bubble after flush, stall_o=1 until the ok, word never appears, state IDLE after.
- **Fetch exception:** `inst_ren_i`=0, `exception_type_i`=0x00000010, pc=0xBFC00001 → next cycle `id_pc_o`=0xBFC00001, `id_inst_o`=0, `id_exception_type_o`=0x10, `id_valid_o`=1.
- **Reset in HOLD:** `resetn`=0 for one edge → all outputs 0. A following `stall_i` drop produces no stale instruction.
